// File: rtl/tdm_pkg.sv
// Shared TDM definitions: FSM state encoding and the sync/parity slot constants
// common to the mux-side framer and the demux receiver.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

    // Slot index that carries the frame-sync flag.
    localparam int unsigned TDM_SYNC_SLOT    = 0;
    // Extra trailing slots appended per frame when parity is enabled.
    localparam int unsigned TDM_PARITY_SLOTS = 1;
    // XOR of all data slots plus the parity slot for a good frame.
    localparam logic        TDM_PARITY_EVEN  = 1'b0;

endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: rotates serial bits into per-channel lanes and presents each
// completed frame as a parallel word. Optional even-parity slot via TDM_DEMUX_PARITY_EN.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N  = 8,
`ifdef TDM_DEMUX_PARITY_EN
    parameter int SW = $clog2(N + 1)
`else
    parameter int SW = $clog2(N)
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          sync,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    output logic [SW-1:0] sel,
    output logic          frame_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic          parity_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int LAST = N + TDM_PARITY_SLOTS - 1;
`else
    localparam int LAST = N - 1;
`endif
    localparam logic [SW-1:0] LAST_IDX = SW'(LAST);
    localparam logic [SW-1:0] SYNC_IDX = SW'(TDM_SYNC_SLOT);

    tdm_state_t    r_state,     w_stateNext;
    logic [SW-1:0] r_cnt,       w_cntNext;
    logic [N-1:0]  r_shadow,    w_shadowNext;
    logic [N-1:0]  r_dout,      w_doutNext;
    logic          r_doutValid, w_doutValidNext;
    logic          r_frameErr,  w_frameErrNext;
    logic [N-1:0]  w_frame;
`ifdef TDM_DEMUX_PARITY_EN
    logic          r_parityErr, w_parityErrNext;
    logic          w_parityOk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_frameErr  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_shadow    <= w_shadowNext;
            r_dout      <= w_doutNext;
            r_doutValid <= w_doutValidNext;
            r_frameErr  <= w_frameErrNext;
`ifdef TDM_DEMUX_PARITY_EN
            r_parityErr <= w_parityErrNext;
`endif
        end
    end

    // w_frame is the shadow register with the incoming bit dropped into its lane.
    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_shadowNext    = r_shadow;
        w_doutNext      = r_dout;
        w_doutValidNext = 1'b0;
        w_frameErrNext  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        w_parityErrNext = 1'b0;
        w_parityOk      = ((^r_shadow) ^ din) == TDM_PARITY_EVEN;
`endif
        w_frame = r_shadow;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == SW'(k)) begin
                w_frame[k] = din;
            end
        end

        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_shadowNext                = '0;
                        w_shadowNext[TDM_SYNC_SLOT] = din;
                        w_cntNext                   = SYNC_IDX + SW'(1);
                        w_stateNext                 = RUN;
                    end
                end
                RUN: begin
                    if (sync && (r_cnt != SYNC_IDX)) begin
                        w_frameErrNext              = 1'b1;
                        w_shadowNext                = '0;
                        w_shadowNext[TDM_SYNC_SLOT] = din;
                        w_cntNext                   = SYNC_IDX + SW'(1);
                    end else if (!sync && (r_cnt == SYNC_IDX)) begin
                        w_frameErrNext = 1'b1;
                        w_cntNext      = '0;
                        w_stateNext    = HUNT;
                    end else if (r_cnt == LAST_IDX) begin
                        w_cntNext = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (w_parityOk) begin
                            w_doutNext      = r_shadow;
                            w_doutValidNext = 1'b1;
                        end else begin
                            w_parityErrNext = 1'b1;
                        end
`else
                        w_shadowNext    = w_frame;
                        w_doutNext      = w_frame;
                        w_doutValidNext = 1'b1;
`endif
                    end else begin
                        w_shadowNext = w_frame;
                        w_cntNext    = r_cnt + SW'(1);
                    end
                end
                default: begin
                    w_stateNext = HUNT;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign sel        = r_cnt;
    assign frame_err  = r_frameErr;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = r_parityErr;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (N=8); parity scenarios run when
// TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

    localparam int N = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOTS = N + 1;
`else
    localparam int SLOTS = N;
`endif
    localparam int SWB = $clog2(SLOTS);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           din;
    logic           din_valid;
    logic           sync;
    logic [N-1:0]   dout;
    logic           dout_valid;
    logic [SWB-1:0] sel;
    logic           frame_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           parity_err;
`endif

    int           nVec = 0;
    int           nMis = 0;
    logic [N-1:0] expDout = '0;

    always #5 clk = ~clk;

    tdm_demux #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sel        (sel),
        .frame_err  (frame_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll(input int expSel, input logic expValid, input logic expFerr, input logic expPerr);
        checkOutput("sel", 32'(sel), 32'(expSel));
        checkOutput("dout_valid", 32'(dout_valid), 32'(expValid));
        checkOutput("frame_err", 32'(frame_err), 32'(expFerr));
        checkOutput("dout", 32'(dout), 32'(expDout));
`ifdef TDM_DEMUX_PARITY_EN
        checkOutput("parity_err", 32'(parity_err), 32'(expPerr));
`else
        if (expPerr) checkOutput("parity_err_unexpected", 32'(expPerr), 32'(0));
`endif
    endtask

    // One valid slot, then the registered outputs are checked 1ns after the edge.
    task automatic applyStimulus(input logic d, input logic s, input int expSel,
                                 input logic expValid, input logic expFerr, input logic expPerr);
        din_valid = 1'b1;
        din       = d;
        sync      = s;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'($urandom);
        sync      = 1'($urandom);
        checkAll(expSel, expValid, expFerr, expPerr);
    endtask

    task automatic idle(input int n, input int expSel);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b0;
            din       = 1'($urandom);
            sync      = 1'($urandom);
            @(posedge clk);
            #1;
            checkAll(expSel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic sendFrame(input logic [N-1:0] frame, input logic [SLOTS-1:0] gapMask,
                             input int startSlot, input logic parityBit);
        logic [N:0] ext;
        logic       good;
        ext = {parityBit, frame};
        for (int slot = startSlot; slot < SLOTS; slot++) begin
            if (slot == SLOTS - 1) begin
                good = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                good = ((^frame) == parityBit);
`endif
                if (good) expDout = frame;
                applyStimulus(ext[slot], slot == 0, 0, good, 1'b0, !good);
            end else begin
                applyStimulus(ext[slot], slot == 0, slot + 1, 1'b0, 1'b0, 1'b0);
                if (gapMask[slot]) idle(2, slot + 1);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        sync      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset, idle");
        idle(20, 0);

        $display("[TB] single frame 8'h4D, then full-rate 8'h81");
        sendFrame(8'h4D, '0, 0, ^8'h4D);
        sendFrame(8'h81, '0, 0, ^8'h81);
        idle(1, 0);

        $display("[TB] gapped frames 8'hA5, 8'h3C");
        sendFrame(8'hA5, SLOTS'(37), 0, ^8'hA5);
        idle(3, 0);
        sendFrame(8'h3C, SLOTS'(74), 0, ^8'h3C);

        $display("[TB] early sync");
        applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h5A, '0, 1, ^8'h5A);

        $display("[TB] missing sync");
        sendFrame(8'hC3, '0, 0, ^8'hC3);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h81, '0, 0, ^8'h81);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expDout = '0;
        checkAll(0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h4D, '0, 0, ^8'h4D);

`ifdef TDM_DEMUX_PARITY_EN
        $display("[TB] parity good 8'h0F, bad 8'hF0");
        sendFrame(8'h0F, '0, 0, 1'b0);
        sendFrame(8'hF0, '0, 0, 1'b1);
        checkOutput("dout_after_parity_err", 32'(dout), 32'h0F);
        idle(1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
